// File: rtl/asr_rcv_pkg.sv
// Shared constants for the ASR receive AXI4-Lite slave: response codes,
// STATUS/REG0 field positions and register-index helpers.
package asr_rcv_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CNT_LSB     = 0;
    localparam int CNT_FIELD_W = 16;
    localparam int EMPTY_BIT   = 16;
    localparam int FULL_BIT    = 17;
    localparam int UNDF_BIT    = 30;
    localparam int OVF_BIT     = 31;

    localparam int IRQ_EN_BIT = 31;
    localparam int THR_W      = 16;

    function automatic int status_idx(input int num_regs);
        return num_regs;
    endfunction

    function automatic int rxdata_idx(input int num_regs);
        return num_regs + 1;
    endfunction

endpackage

// File: rtl/asr_rcv_fifo.sv
// Synchronous receive FIFO. The caller only asserts push_i when a slot is
// free (or a pop frees one this cycle) and pop_i only when non-empty.
module asr_rcv_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          data_i,
    input  logic                       pop_i,
    output logic [DATA_W-1:0]          data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;

    // NOTE: storage carries no reset; valid entries are tracked by the
    // pointers and count, so clearing the array would only cost reset fan-out.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: a default before the case keeps every path assigned, so no latch.
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/asr_rcv_axil_regs.sv
// AXI4-Lite slave for the ASR receive path: RW control registers, STATUS
// with sticky W1C flags, a popping RXDATA port and a threshold interrupt.
module asr_rcv_axil_regs
    import asr_rcv_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int NUM_REGS   = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [ADDR_W-1:0]     AWADDR,
    input  logic [2:0]            AWPROT,
    input  logic                  AWVALID,
    output logic                  AWREADY,
    input  logic [DATA_W-1:0]     WDATA,
    input  logic [DATA_W/8-1:0]   WSTRB,
    input  logic                  WVALID,
    output logic                  WREADY,
    output logic [1:0]            BRESP,
    output logic                  BVALID,
    input  logic                  BREADY,
    input  logic [ADDR_W-1:0]     ARADDR,
    input  logic [2:0]            ARPROT,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    output logic [DATA_W-1:0]     RDATA,
    output logic [1:0]            RRESP,
    output logic                  RVALID,
    input  logic                  RREADY,
    input  logic                  rx_valid,
    input  logic [DATA_W-1:0]     rx_data,
    output logic                  irq
);

    localparam int IDX_W  = ADDR_W - 2;
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(status_idx(NUM_REGS));
    localparam logic [IDX_W-1:0] RX_IDX     = IDX_W'(rxdata_idx(NUM_REGS));

    logic                ready_en_q;
    logic                aw_held_q, w_held_q, bvalid_q, rvalid_q;
    logic [IDX_W-1:0]    aw_idx_q;
    logic [DATA_W-1:0]   w_data_q, rdata_q;
    logic [STRB_W-1:0]   w_strb_q;
    logic [1:0]          bresp_q, rresp_q;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic                ovf_q, ovf_d, undf_q, undf_d;

    logic                aw_hs, w_hs, ar_hs, commit, rx_read;
    logic [IDX_W-1:0]    wr_idx, rd_idx;
    logic [DATA_W-1:0]   wr_data, rd_data, status;
    logic [STRB_W-1:0]   wr_strb;
    logic [1:0]          wr_resp, rd_resp;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_W-1:0]   fifo_head;
    logic [CNT_W-1:0]    fifo_count;

    logic unused_ok;
    assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};

    // Ready stays low until the first edge after reset is released.
    assign AWREADY = ready_en_q && !aw_held_q && !bvalid_q;
    assign WREADY  = ready_en_q && !w_held_q && !bvalid_q;
    assign ARREADY = ready_en_q && !rvalid_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign RVALID  = rvalid_q;
    assign RRESP   = rresp_q;
    assign RDATA   = rdata_q;

    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign ar_hs   = ARVALID && ARREADY;
    assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_idx  = aw_held_q ? aw_idx_q : AWADDR[ADDR_W-1:2];
    assign wr_data = w_held_q ? w_data_q : WDATA;
    assign wr_strb = w_held_q ? w_strb_q : WSTRB;
    assign rd_idx  = ARADDR[ADDR_W-1:2];

    // A pop frees a slot for a same-cycle push; an empty read still underflows.
    assign rx_read   = ar_hs && (rd_idx == RX_IDX);
    assign fifo_pop  = rx_read && !fifo_empty;
    assign fifo_push = rx_valid && (!fifo_full || fifo_pop);

    asr_rcv_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (ACLK),
        .rst_i   (ARESET),
        .push_i  (fifo_push),
        .data_i  (rx_data),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        status = '0;
        status[CNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(fifo_count);
        status[EMPTY_BIT] = fifo_empty;
        status[FULL_BIT]  = fifo_full;
        status[UNDF_BIT]  = undf_q;
        status[OVF_BIT]   = ovf_q;
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_SLVERR;
        if (rd_idx == STATUS_IDX) begin
            rd_data = status;
            rd_resp = RESP_OKAY;
        end else if (rd_idx == RX_IDX) begin
            rd_data = fifo_empty ? '0 : fifo_head;
            rd_resp = RESP_OKAY;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (rd_idx == IDX_W'(i)) begin
                    rd_data = regs_q[i];
                    rd_resp = RESP_OKAY;
                end
            end
        end
    end

    always_comb begin
        regs_d  = regs_q;
        wr_resp = RESP_SLVERR;
        if (wr_idx == STATUS_IDX || wr_idx == RX_IDX) begin
            wr_resp = RESP_OKAY;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
                wr_resp = RESP_OKAY;
                for (int b = 0; b < STRB_W; b++) begin
                    if (commit && wr_strb[b]) regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
                end
            end
        end
    end

    // Sticky flags: a W1C and a set in the same cycle resolve to set.
    always_comb begin
        ovf_d  = ovf_q;
        undf_d = undf_q;
        if (commit && wr_idx == STATUS_IDX && wr_strb[3]) begin
            if (wr_data[OVF_BIT])  ovf_d  = 1'b0;
            if (wr_data[UNDF_BIT]) undf_d = 1'b0;
        end
        if (rx_valid && fifo_full && !fifo_pop) ovf_d  = 1'b1;
        if (rx_read && fifo_empty)              undf_d = 1'b1;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            ovf_q      <= 1'b0;
            undf_q     <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= wr_resp;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    aw_idx_q  <= AWADDR[ADDR_W-1:2];
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    w_data_q <= WDATA;
                    w_strb_q <= WSTRB;
                end
                if (bvalid_q && BREADY) bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data;
                rresp_q  <= rd_resp;
            end else if (rvalid_q && RREADY) begin
                rvalid_q <= 1'b0;
            end
            regs_q <= regs_d;
            ovf_q  <= ovf_d;
            undf_q <= undf_d;
        end
    end

    assign irq = regs_q[0][IRQ_EN_BIT] &&
                 (status[CNT_LSB +: CNT_FIELD_W] >= regs_q[0][THR_W-1:0]);

endmodule
